// File: rtl/econet_rx_frame_ctrl.sv
// econet_rx_frame_ctrl: unloads FCS-checked frames from the receive ring as a byte stream
// Ports:
//   sys_clk, reset                 clock, asynchronous active-high reset
//   enable                         allows a new frame to be accepted from IDLE
//   frame_valid/start/end, frame_ack   pending-frame descriptor and its one-cycle clear pulse
//   buf_rd/buf_addr/buf_data       ring word read (data valid the cycle after buf_rd)
//   out_byte/valid/ready/first/last    payload byte stream with handshake
//   frame_len, busy                payload length of the current/last frame, non-IDLE flag
//   overrun/overrun_clr            sticky "frame arrived while unloading" flag and its clear
//   runt_cnt                       saturating count of discarded runt frames
module econet_rx_frame_ctrl #(
    parameter int ECO_CNTWIDTH = 9,
    parameter int FCS_BYTES = 2
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    frame_valid,
    input  logic [ECO_CNTWIDTH-1:0] frame_start,
    input  logic [ECO_CNTWIDTH-1:0] frame_end,
    output logic                    buf_rd,
    output logic [ECO_CNTWIDTH-3:0] buf_addr,
    input  logic [31:0]             buf_data,
    output logic                    frame_ack,
    output logic [7:0]              out_byte,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_first,
    output logic                    out_last,
    output logic [ECO_CNTWIDTH-1:0] frame_len,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    overrun_clr,
    output logic [7:0]              runt_cnt
);
    localparam logic [2:0] IDLE = 3'd0, CHECK = 3'd1, ACK = 3'd2, FETCH = 3'd3,
                           WAIT = 3'd4, SHIFT = 3'd5, DONE = 3'd6;
    localparam logic [ECO_CNTWIDTH-1:0] FCS = ECO_CNTWIDTH'(FCS_BYTES);
    localparam logic [ECO_CNTWIDTH-1:0] ONE = ECO_CNTWIDTH'(1);
    logic [2:0]              state;
    logic [ECO_CNTWIDTH-1:0] ptr, raw, remaining;
    logic [31:0]             word;
    logic                    discard, first;
    logic                    unloading;
    assign busy      = state != IDLE;
    assign buf_rd    = state == FETCH;
    assign frame_ack = state == ACK;
    assign out_valid = state == SHIFT;
    assign buf_addr  = ptr[ECO_CNTWIDTH-1:2];
    assign out_byte  = word[{ptr[1:0], 3'b000} +: 8];
    assign out_first = out_valid && first;
    assign out_last  = out_valid && remaining == ONE;
    assign unloading = state == FETCH || state == WAIT || state == SHIFT || state == DONE;
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            raw       <= '0;
            remaining <= '0;
            frame_len <= '0;
            word      <= '0;
            discard   <= 1'b0;
            first     <= 1'b0;
            overrun   <= 1'b0;
            runt_cnt  <= '0;
        end else begin
            // a set in the same cycle as a clear wins
            overrun <= (frame_valid && unloading) || (overrun && !overrun_clr);
            case (state)
                IDLE: if (enable && frame_valid) begin
                    ptr   <= frame_start;
                    raw   <= frame_end - frame_start;
                    state <= CHECK;
                end
                CHECK: begin
                    discard <= raw <= FCS;
                    first   <= 1'b1;
                    if (raw <= FCS) begin
                        if (runt_cnt != 8'hFF) runt_cnt <= runt_cnt + 8'd1;
                    end else begin
                        frame_len <= raw - FCS;
                        remaining <= raw - FCS;
                    end
                    state <= ACK;
                end
                ACK:   state <= discard ? IDLE : FETCH;
                FETCH: state <= WAIT;
                WAIT: begin
                    word  <= buf_data;
                    state <= SHIFT;
                end
                SHIFT: if (out_ready) begin
                    ptr       <= ptr + ONE;
                    remaining <= remaining - ONE;
                    first     <= 1'b0;
                    // lane 3 consumed means the next byte starts a new ring word
                    state     <= remaining == ONE ? DONE : ptr[1:0] == 2'd3 ? FETCH : SHIFT;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_econet_rx_frame_ctrl.sv
// tb_econet_rx_frame_ctrl: randomized self-checking bench with a ring/frame reference model
module tb_econet_rx_frame_ctrl;
    localparam int FCS = 2;
    logic       sys_clk = 1'b0;
    logic       reset, enable, frame_valid, out_ready, overrun_clr;
    logic [8:0] frame_start, frame_end;
    logic [31:0] buf_data;
    logic       buf_rd, frame_ack, out_valid, out_first, out_last, busy, overrun;
    logic [6:0] buf_addr;
    logic [7:0] out_byte, runt_cnt;
    logic [8:0] frame_len;

    econet_rx_frame_ctrl dut (
        .sys_clk(sys_clk), .reset(reset), .enable(enable), .frame_valid(frame_valid),
        .frame_start(frame_start), .frame_end(frame_end), .buf_rd(buf_rd), .buf_addr(buf_addr),
        .buf_data(buf_data), .frame_ack(frame_ack), .out_byte(out_byte), .out_valid(out_valid),
        .out_ready(out_ready), .out_first(out_first), .out_last(out_last), .frame_len(frame_len),
        .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr), .runt_cnt(runt_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    logic [7:0] ring [512];
    logic [7:0] byte_q [$];
    bit         first_q [$];
    bit         last_q [$];
    logic [6:0] addr_q [$];
    int         n_checks = 0, n_errors = 0;
    int         ack_cnt, stab_err, rdy_mode;
    bit         rd_pend, hold_v, hold_f, hold_l;
    logic [6:0] rd_addr;
    logic [7:0] hold_b, exp_runt;
    logic [8:0] exp_len;

    function automatic logic [31:0] word_at(input logic [6:0] a);
        int b;
        b = int'(a) * 4;
        return {ring[b+3], ring[b+2], ring[b+1], ring[b]};
    endfunction

    // one clock of the environment: ring memory, upstream descriptor, sink
    task automatic cycle();
        @(posedge sys_clk);
        #1;
        if (rd_pend) buf_data = word_at(rd_addr);
        rd_pend = buf_rd;
        rd_addr = buf_addr;
        if (buf_rd) addr_q.push_back(buf_addr);
        if (frame_ack) begin
            ack_cnt++;
            frame_valid = 1'b0;
        end
        if (hold_v && (!out_valid || out_byte !== hold_b || out_first !== hold_f || out_last !== hold_l))
            stab_err++;
        out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~out_ready : 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
            byte_q.push_back(out_byte);
            first_q.push_back(out_first);
            last_q.push_back(out_last);
        end
        hold_v = out_valid && !out_ready;
        hold_b = out_byte;
        hold_f = out_first;
        hold_l = out_last;
    endtask

    // mode 0: plain, 1: post a second frame during SHIFT, 2: drop enable during SHIFT
    task automatic run_frame(input int s, input int e, input int mode, input int s2, input int e2);
        int raw, n, k, bad;
        bit inj;
        logic [6:0] exp_a [$];
        raw = (e - s) & 511;
        n = raw > FCS ? raw - FCS : 0;
        byte_q.delete(); first_q.delete(); last_q.delete(); addr_q.delete();
        ack_cnt = 0; stab_err = 0; inj = 0; k = 0;
        frame_start = s[8:0]; frame_end = e[8:0]; frame_valid = 1'b1; enable = 1'b1;
        cycle();
        while (busy && k < 4000) begin
            if (mode != 0 && out_valid && !inj) begin
                inj = 1;
                if (mode == 1) begin
                    frame_start = s2[8:0]; frame_end = e2[8:0]; frame_valid = 1'b1;
                end else enable = 1'b0;
            end
            cycle();
            k++;
        end
        if (raw <= FCS) exp_runt = exp_runt == 8'hFF ? 8'hFF : exp_runt + 8'd1;
        else exp_len = n[8:0];
        for (int i = 0; i < n; i++)
            if (i == 0 || ((s + i) & 3) == 0) exp_a.push_back(7'(((s + i) & 511) >> 2));
        n_checks++;
        if (busy) begin n_errors++; $display("FAIL timeout s=%h: busy=%b required 0", s, busy); end
        n_checks++;
        if (ack_cnt !== 1) begin n_errors++; $display("FAIL ack_count s=%h: got %0d required 1", s, ack_cnt); end
        n_checks++;
        if (frame_len !== exp_len) begin n_errors++; $display("FAIL frame_len s=%h: got %0d required %0d", s, frame_len, exp_len); end
        n_checks++;
        if (runt_cnt !== exp_runt) begin n_errors++; $display("FAIL runt_cnt s=%h: got %0d required %0d", s, runt_cnt, exp_runt); end
        n_checks++;
        if (byte_q.size() !== n) begin n_errors++; $display("FAIL byte_count s=%h: got %0d required %0d", s, byte_q.size(), n); end
        bad = 0;
        for (int i = 0; i < n && i < byte_q.size(); i++)
            if (byte_q[i] !== ring[(s + i) & 511] || first_q[i] !== (i == 0) || last_q[i] !== (i == n - 1)) bad++;
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL byte_data s=%h: %0d bytes wrong, required 0", s, bad); end
        bad = addr_q.size() == exp_a.size() ? 0 : 1;
        for (int i = 0; i < exp_a.size() && i < addr_q.size(); i++)
            if (addr_q[i] !== exp_a[i]) bad++;
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL buf_addr s=%h: %0d reads wrong (got %0d reads, required %0d)", s, bad, addr_q.size(), exp_a.size()); end
        n_checks++;
        if (stab_err != 0) begin n_errors++; $display("FAIL stable s=%h: %0d changes while stalled, required 0", s, stab_err); end
        enable = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; frame_valid = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
        frame_start = '0; frame_end = '0; buf_data = '0;
        rd_pend = 0; hold_v = 0; rdy_mode = 0; exp_runt = '0; exp_len = '0;
        repeat (2) @(posedge sys_clk);
        #1;
        n_checks++;
        if ({buf_rd, frame_ack, out_valid, out_first, out_last, busy, overrun, frame_len, runt_cnt, out_byte, buf_addr} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {buf_rd, frame_ack, out_valid, out_first, out_last, busy, overrun, frame_len, runt_cnt, out_byte, buf_addr});
        end
        reset = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_basic();
        rdy_mode = 0;
        run_frame(32'h010, 32'h01A, 0, 0, 0);
    endtask

    task automatic test_wrap();
        rdy_mode = 0;
        run_frame(32'h1FE, 32'h006, 0, 0, 0);
    endtask

    task automatic test_runts();
        rdy_mode = 0;
        run_frame(32'h020, 32'h020, 0, 0, 0);
        run_frame(32'h020, 32'h022, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        rdy_mode = 1;
        run_frame(32'h101, 32'h117, 0, 0, 0);
        run_frame(32'h1F9, 32'h00D, 0, 0, 0);
    endtask

    task automatic test_random();
        int s;
        rdy_mode = 2;
        for (int i = 0; i < 8; i++) begin
            s = $urandom_range(0, 511);
            run_frame(s, (s + $urandom_range(0, 40)) & 511, 0, 0, 0);
        end
    endtask

    task automatic test_max();
        int s;
        rdy_mode = 2;
        s = $urandom_range(0, 511);
        run_frame(s, (s + 511) & 511, 0, 0, 0);
    endtask

    task automatic test_enable();
        rdy_mode = 0;
        enable = 1'b0; frame_start = 9'h0A5; frame_end = 9'h0B3; frame_valid = 1'b1; ack_cnt = 0;
        repeat (5) cycle();
        n_checks++;
        if (busy !== 1'b0 || ack_cnt != 0) begin n_errors++; $display("FAIL enable_gate: busy=%b acks=%0d required 0/0", busy, ack_cnt); end
        run_frame(32'h0A5, 32'h0B3, 2, 0, 0);
    endtask

    task automatic test_overrun();
        rdy_mode = 2;
        n_checks++;
        if (overrun !== 1'b0) begin n_errors++; $display("FAIL overrun_idle: got %b required 0", overrun); end
        run_frame(32'h040, 32'h05A, 1, 32'h133, 32'h147);
        n_checks++;
        if (overrun !== 1'b1 || frame_valid !== 1'b1) begin n_errors++; $display("FAIL overrun_set: overrun=%b pending=%b required 1/1", overrun, frame_valid); end
        run_frame(32'h133, 32'h147, 0, 0, 0);
        overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin n_errors++; $display("FAIL overrun_clr: got %b required 0", overrun); end
    endtask

    task automatic test_reset_mid();
        int k;
        rdy_mode = 0; k = 0;
        byte_q.delete();
        frame_start = 9'h080; frame_end = 9'h0A0; frame_valid = 1'b1; enable = 1'b1;
        while (!(out_valid && byte_q.size() >= 3) && k < 100) begin
            cycle();
            k++;
        end
        n_checks++;
        if (!out_valid) begin n_errors++; $display("FAIL reach_shift: out_valid=%b required 1", out_valid); end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({buf_rd, frame_ack, out_valid, out_first, out_last, busy, overrun, frame_len, runt_cnt, out_byte, buf_addr} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: got %h required 0",
                     {buf_rd, frame_ack, out_valid, out_first, out_last, busy, overrun, frame_len, runt_cnt, out_byte, buf_addr});
        end
        hold_v = 0; rd_pend = 0; ack_cnt = 0; exp_runt = '0; exp_len = '0;
        #2;
        reset = 1'b0;
        repeat (4) cycle();
        n_checks++;
        if (ack_cnt != 0 || busy !== 1'b0) begin n_errors++; $display("FAIL reset_no_ack: acks=%0d busy=%b required 0/0", ack_cnt, busy); end
        run_frame(32'h0C3, 32'h0D9, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ring[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_wrap();
        test_runts();
        test_backpressure();
        test_random();
        test_max();
        test_enable();
        test_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
